// File: rtl/prim_ram_req_arb_if.sv
// Single-port RAM request/response bundle shared by the arbiter and the RAM.
// The arbiter drives the request side and consumes the in-order read response.
interface prim_ram_req_arb_if #(
    parameter int unsigned Width = 32,
    parameter int unsigned Aw    = 9
);
    logic             req;
    logic             write;
    logic [Aw-1:0]    addr;
    logic [Width-1:0] wdata;
    logic             rvalid;
    logic [Width-1:0] rdata;
    logic [1:0]       rerror;

    modport master (
        output req,
        output write,
        output addr,
        output wdata,
        input  rvalid,
        input  rdata,
        input  rerror
    );

    modport slave (
        input  req,
        input  write,
        input  addr,
        input  wdata,
        output rvalid,
        output rdata,
        output rerror
    );
endinterface

// File: rtl/prim_ram_req_arb.sv
// Round-robin arbiter sharing one RAM port among N requesters.
// Read issuer IDs are queued so in-order responses route back to their owner.
module prim_ram_req_arb #(
    parameter int unsigned N      = 4,
    parameter int unsigned Width  = 32,
    parameter int unsigned Aw     = 9,
    parameter int unsigned MaxOut = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    input  logic [N-1:0]         write_i,
    input  logic [N*Aw-1:0]      addr_i,
    input  logic [N*Width-1:0]   wdata_i,
    output logic [N-1:0]         rvalid_o,
    output logic [Width-1:0]     rdata_o,
    output logic [1:0]           rerror_o,
    prim_ram_req_arb_if.master   ram,
    output logic                 err_o
);
    localparam int unsigned IdW  = $clog2(N);
    localparam int unsigned PtrW = $clog2(MaxOut);
    localparam int unsigned CntW = $clog2(MaxOut + 1);

    logic [IdW-1:0]  ptr_q;
    logic [IdW-1:0]  sel;
    logic [IdW-1:0]  idx;
    logic            found;
    logic [N-1:0]    elig;
    logic            space;
    logic            push;
    logic            pop;
    logic [IdW-1:0]  ids_q [MaxOut];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    // A full FIFO still accepts a read when a response pops it this cycle.
    assign space = (cnt_q < CntW'(MaxOut)) || ram.rvalid;
    assign elig  = req_i & (write_i | {N{space}}) & {N{rst_ni}};
    assign pop   = rst_ni && ram.rvalid && (cnt_q != '0);
    assign push  = found && !write_i[sel];

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = IdW'((int'(ptr_q) + i) % int'(N));
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        gnt_o     = '0;
        ram.req   = found;
        ram.write = 1'b0;
        ram.addr  = '0;
        ram.wdata = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (found && sel == IdW'(k)) begin
                gnt_o[k]  = 1'b1;
                ram.write = write_i[k];
                ram.addr  = addr_i[k*Aw +: Aw];
                ram.wdata = wdata_i[k*Width +: Width];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (pop) rvalid_o[ids_q[rd_q]] = 1'b1;
    end

    assign rdata_o  = ram.rdata;
    assign rerror_o = ram.rerror;
    assign err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (found) begin
                ptr_q <= (sel == IdW'(N - 1)) ? '0 : sel + IdW'(1);
            end
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop) rd_q <= rd_q + PtrW'(1);
            if (push && !pop) cnt_q <= cnt_q + CntW'(1);
            if (pop && !push) cnt_q <= cnt_q - CntW'(1);
            if (ram.rvalid && cnt_q == '0) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) ids_q[wr_q] <= sel;
    end
endmodule
